// File: rtl/wpa_pkg.sv
// Shared types and wildcard decode constants for the wildcard priority arbiter.
package wpa_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        CLS_DEF = 2'd0,
        CLS_P3  = 2'd1,
        CLS_P2  = 2'd2,
        CLS_P1  = 2'd3
    } cls_e;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // A code matches a rule when the bits selected by MSK equal PAT.
    localparam logic [CODE_W-1:0] PAT_P1 = 3'b000;
    localparam logic [CODE_W-1:0] MSK_P1 = 3'b100;
    localparam logic [CODE_W-1:0] PAT_P2 = 3'b100;
    localparam logic [CODE_W-1:0] MSK_P2 = 3'b110;
    localparam logic [CODE_W-1:0] PAT_P3 = 3'b111;
    localparam logic [CODE_W-1:0] MSK_P3 = 3'b111;

endpackage

// File: rtl/wpa_classify.sv
// Combinational wildcard decode of one command code into a priority class.
module wpa_classify
    import wpa_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output cls_e              cls_c
);

    // Equality (not casez) so an unknown compared bit never counts as a match.
    always_comb begin
        cls_c = CLS_DEF;
        if ((code & MSK_P1) == PAT_P1) begin
            cls_c = CLS_P1;
        end else if ((code & MSK_P2) == PAT_P2) begin
            cls_c = CLS_P2;
        end else if ((code & MSK_P3) == PAT_P3) begin
            cls_c = CLS_P3;
        end
    end

endmodule

// File: rtl/wildcard_prio_arbiter.sv
// Class-priority arbiter with round-robin inside a class, grant hold until done,
// and a forced release after HOLD_MAX cycles.
module wildcard_prio_arbiter
    import wpa_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*CODE_W-1:0]    code,
    input  logic                       done,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic [1:0]                 gnt_class,
    output logic                       busy,
    output logic                       timeout
);

    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    cls_e              cls_c [N_REQ];
    cls_e              max_cls;
    logic [ID_W-1:0]   win_id;
    logic              win_found;

    state_e            state_q, state_d;
    cls_e              gnt_class_q, gnt_class_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]  gnt_d;
    logic [ID_W-1:0]   gnt_id_d;
    logic              busy_d;
    logic              timeout_d;
    logic              gnt_req;
    logic [ID_W-1:0]   next_ptr;

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_cls
        wpa_classify u_classify (
            .code  (code[g*CODE_W +: CODE_W]),
            .cls_c (cls_c[g])
        );
    end

    // Highest class among active requests, then first match at or after rr_ptr.
    always_comb begin
        max_cls   = CLS_DEF;
        win_id    = '0;
        win_found = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req[i] && (cls_c[i] > max_cls)) begin
                max_cls = cls_c[i];
            end
        end
        for (int k = 0; k < int'(N_REQ); k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(N_REQ)) begin
                idx = idx - int'(N_REQ);
            end
            if (!win_found && req[idx] && (cls_c[idx] == max_cls)) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign gnt_req  = req[gnt_id];
    assign next_ptr = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt;
        gnt_id_d    = gnt_id;
        gnt_class_d = gnt_class_q;
        busy_d      = busy;
        timeout_d   = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = GRANT;
                    gnt_d       = N_REQ'(1) << win_id;
                    gnt_id_d    = win_id;
                    gnt_class_d = max_cls;
                    busy_d      = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (done || !gnt_req || (hold_cnt_q == HOLD_LAST)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    rr_ptr_d  = next_ptr;
                    timeout_d = !done && gnt_req;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt         <= '0;
            gnt_id      <= '0;
            gnt_class_q <= CLS_DEF;
            busy        <= 1'b0;
            timeout     <= 1'b0;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt         <= gnt_d;
            gnt_id      <= gnt_id_d;
            gnt_class_q <= gnt_class_d;
            busy        <= busy_d;
            timeout     <= timeout_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt_class = gnt_class_q;

endmodule

// File: tb/tb_wildcard_prio_arbiter.sv
// Directed self-checking bench for wildcard_prio_arbiter (N_REQ=4, HOLD_MAX=8).
module tb_wildcard_prio_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] code;
    logic        done;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic [1:0]  gnt_class;
    logic        busy;
    logic        timeout;

    int n_tests;
    int n_fail;

    wildcard_prio_arbiter #(.N_REQ(4), .HOLD_MAX(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .code      (code),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_class (gnt_class),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode; unknown bits only satisfy don't-care positions.
    function automatic int ref_cls(input logic [2:0] v);
        if (v[2] === 1'b0)                      return 3;
        if (v[2] === 1'b1 && v[1] === 1'b0)     return 2;
        if (v[2] === 1'b1 && v[1] === 1'b1 && v[0] === 1'b1) return 1;
        return 0;
    endfunction

    logic [2:0] xv [3];
    int         xexp [3];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        req   = '0;
        code  = '0;
        done  = 1'b0;
        tick();
        tick();
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_id", int'(gnt_id), 0);
        check("rst_cls", int'(gnt_class), 0);
        check("rst_to", int'(timeout), 0);

        // First grant right after reset
        rst_n = 1'b1;
        req   = 4'b0001;
        code  = {3'b000, 3'b000, 3'b000, 3'b001};
        tick();
        check("first_gnt", int'(gnt), 1);
        check("first_cls", int'(gnt_class), 3);
        check("first_busy", int'(busy), 1);
        req = '0;
        tick();
        check("drop_release", int'(gnt), 0);
        check("drop_no_to", int'(timeout), 0);
        tick();

        // Class priority: ids 0..3 carry 110,111,101,011
        code = {3'b011, 3'b101, 3'b111, 3'b110};
        req  = 4'b1111;
        tick();
        check("prio_id3", int'(gnt_id), 3);
        check("prio_cls3", int'(gnt_class), 3);
        for (int s = 2; s >= 0; s--) begin
            done = 1'b1;
            req  = 4'b1111 >> (3 - s);
            tick();
            done = 1'b0;
            check("prio_idle", int'(gnt), 0);
            tick();
            check("prio_id", int'(gnt_id), s);
            check("prio_cls", int'(gnt_class), s);
            check("prio_gnt", int'(gnt), 1 << s);
        end
        done = 1'b1;
        req  = '0;
        tick();
        done = 1'b0;
        tick();

        // Round-robin within one class from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        code = {4{3'b010}};
        req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_id", int'(gnt_id), k % 4);
            check("rr_gnt", int'(gnt), 1 << (k % 4));
            done = 1'b1;
            tick();
            done = 1'b0;
            check("rr_release", int'(gnt), 0);
        end
        req = '0;
        tick();

        // Timeout: single requester, no done
        req = 4'b0001;
        tick();
        for (int c = 0; c < 8; c++) begin
            check("to_hold_gnt", int'(gnt), 1);
            check("to_hold_pulse", int'(timeout), 0);
            tick();
        end
        check("to_released", int'(gnt), 0);
        check("to_pulse", int'(timeout), 1);
        check("to_busy", int'(busy), 0);
        tick();
        check("to_regrant", int'(gnt), 1);
        check("to_pulse_once", int'(timeout), 0);
        // done coincides with the timeout edge
        for (int c = 0; c < 7; c++) tick();
        check("to_still_held", int'(gnt), 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("done_at_to_gnt", int'(gnt), 0);
        check("done_at_to_pulse", int'(timeout), 0);
        req = '0;
        tick();

        // Unknown bits in codes
        xv[0] = 3'b1x1;
        xv[1] = 3'b0x1;
        xv[2] = 3'bx00;
        for (int t = 0; t < 3; t++) begin
            xexp[t] = ref_cls(xv[t]);
            code = {9'b0, xv[t]};
            req  = 4'b0001;
            tick();
            check("x_cls", int'(gnt_class), xexp[t]);
            req = '0;
            tick();
            tick();
        end

        // Reset in the middle of a grant clears the round-robin pointer
        code = {4{3'b010}};
        req  = 4'b0100;
        tick();
        check("mid_pre_id2", int'(gnt_id), 2);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b1111;
        tick();
        check("mid_ptr_id3", int'(gnt_id), 3);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_gnt", int'(gnt), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_id", int'(gnt_id), 0);
        rst_n = 1'b1;
        tick();
        check("mid_after_id0", int'(gnt_id), 0);
        check("mid_after_gnt", int'(gnt), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
